// File: rtl/sdf_ntt_stream.sv
// Radix-2 DIF single-delay-feedback NTT pipeline, one coefficient per accepted cycle.
// Forward/inverse mode is latched per frame and travels down the stages with its data.
module sdf_ntt_stream #(
    parameter int DATA_W = 16,
    parameter int LOG_N  = 4,
    parameter int MODULO = 7681,
    parameter int N_INV  = 7201
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    inverse,
    output logic [LOG_N*LOG_N-1:0]  tw_addr,
    input  logic [LOG_N*DATA_W-1:0] tw_data,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    done_tick
);
    localparam int N  = 1 << LOG_N;
    localparam int EW = LOG_N - 1;
    localparam logic [DATA_W-1:0]   Q_N    = DATA_W'(MODULO);
    localparam logic [DATA_W:0]     Q_EXT  = (DATA_W + 1)'(MODULO);
    localparam logic [2*DATA_W-1:0] Q_WIDE = (2 * DATA_W)'(MODULO);
    localparam logic [DATA_W-1:0]   NINV   = DATA_W'(N_INV);

    function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= Q_EXT) sum = sum - Q_EXT;
        return sum[DATA_W-1:0];
    endfunction

    // Wrapping subtraction plus q lands back in range because the true result is below q.
    function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] diff;
        diff = a - b;
        if (a < b) diff = diff + Q_N;
        return diff;
    endfunction

    function automatic logic [DATA_W-1:0] mul_mod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] prod;
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        return DATA_W'(prod % Q_WIDE);
    endfunction

    genvar s;
    generate
        for (s = 0; s < LOG_N; s++) begin : g_stage
            localparam int D  = N >> (s + 1);
            localparam int CW = LOG_N - s;

            logic [CW-1:0]     cnt;
            logic              mode;
            logic              mode_src;
            logic              phase_b;
            logic [DATA_W-1:0] x;
            logic [DATA_W-1:0] a;
            logic [DATA_W-1:0] y;
            logic [DATA_W-1:0] fifo_in;
            logic [DATA_W-1:0] fifo [D];

            if (s == 0) begin : g_src
                assign x        = in_data;
                assign mode_src = inverse;
            end else begin : g_src
                assign x        = g_stage[s-1].y;
                assign mode_src = g_stage[s-1].mode;
            end

            assign a       = fifo[D-1];
            assign phase_b = cnt[CW-1];
            assign y       = phase_b ? add_mod(a, x) : a;

            // The final stage always rotates by 1, so its ROM slice is ignored.
            if (D == 1) begin : g_tw
                logic unused_tw;
                assign unused_tw = ^tw_data[s*DATA_W +: DATA_W];
                assign fifo_in   = phase_b ? sub_mod(a, x) : x;
                assign tw_addr[s*LOG_N +: LOG_N] = {mode, {EW{1'b0}}};
            end else begin : g_tw
                logic [EW-1:0] expo;
                assign expo    = phase_b ? (EW'(cnt[CW-2:0]) << s) : '0;
                assign fifo_in = phase_b ? mul_mod(sub_mod(a, x), tw_data[s*DATA_W +: DATA_W]) : x;
                assign tw_addr[s*LOG_N +: LOG_N] = {mode, expo};
            end

            // Relatching at every block start is safe: the upstream flag holds this frame until after our last block.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt  <= '0;
                    mode <= 1'b0;
                    for (int i = 0; i < D; i++) fifo[i] <= '0;
                end else if (in_valid) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '0) mode <= mode_src;
                    fifo[0] <= fifo_in;
                    for (int i = 1; i < D; i++) fifo[i] <= fifo[i-1];
                end
            end
        end
    endgenerate

    logic [LOG_N:0]    fill;
    logic              filled;
    logic              last_mode;
    logic [DATA_W-1:0] last_y;

    assign filled    = fill[LOG_N];
    assign last_mode = g_stage[LOG_N-1].mode;
    assign last_y    = g_stage[LOG_N-1].y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill     <= '0;
            out_data <= '0;
        end else if (in_valid) begin
            if (!filled) fill <= fill + 1'b1;
            out_data <= last_mode ? mul_mod(last_y, NINV) : last_y;
        end
    end

    // Once filled, the stage-0 counter equals the index of the output being presented.
    assign out_valid = in_valid & filled;
    assign done_tick = out_valid & (&g_stage[0].cnt);
endmodule

// File: tb/tb_sdf_ntt_stream.sv
// Directed vector bench for the 16-point SDF NTT stream: behavioural twiddle ROM,
// direct-DFT golden model, stall, mode-switch and mid-frame reset sequences.
module tb_sdf_ntt_stream;
    localparam int DATA_W = 16;
    localparam int LOG_N  = 4;
    localparam int N      = 16;
    localparam int Q      = 7681;
    localparam int N_INV  = 7201;
    localparam int NVEC   = 8;

    typedef logic [N-1:0][DATA_W-1:0] frame_t;
    typedef struct {
        bit     inv;
        frame_t x;
        frame_t exp;
    } vec_t;

    logic                    clk      = 1'b0;
    logic                    rst_n    = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    inverse  = 1'b0;
    logic [DATA_W-1:0]       in_data  = '0;
    logic [LOG_N*LOG_N-1:0]  tw_addr;
    logic [LOG_N*DATA_W-1:0] tw_data;
    logic                    out_valid;
    logic                    done_tick;
    logic [DATA_W-1:0]       out_data;

    sdf_ntt_stream #(
        .DATA_W(DATA_W), .LOG_N(LOG_N), .MODULO(Q), .N_INV(N_INV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .inverse(inverse), .tw_addr(tw_addr), .tw_data(tw_data),
        .out_valid(out_valid), .out_data(out_data), .done_tick(done_tick)
    );

    always #5 clk = ~clk;

    int unsigned pw  [N];
    int unsigned ipw [N];

    always_comb begin
        tw_data = '0;
        for (int s = 0; s < LOG_N; s++) begin
            if (tw_addr[s*LOG_N + LOG_N - 1])
                tw_data[s*DATA_W +: DATA_W] = DATA_W'(ipw[{1'b0, tw_addr[s*LOG_N +: LOG_N-1]}]);
            else
                tw_data[s*DATA_W +: DATA_W] = DATA_W'(pw[{1'b0, tw_addr[s*LOG_N +: LOG_N-1]}]);
        end
    end

    vec_t             vecs     [NVEC];
    string            vec_name [NVEC];
    logic [DATA_W-1:0] got_data [$];
    bit               got_done [$];
    int               acc;
    int               first_acc;
    int               n_checks;
    int               n_fail;

    function automatic longint unsigned modpow(input longint unsigned b, input int e);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * (b % Q)) % Q;
        return r;
    endfunction

    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < LOG_N; i++) if (v[i]) r = r | (1 << (LOG_N - 1 - i));
        return r;
    endfunction

    // Direct O(N^2) transform, results placed in bit-reversed order.
    function automatic frame_t golden(input frame_t x, input bit inv);
        frame_t          y;
        longint unsigned sum;
        int              k;
        for (int m = 0; m < N; m++) begin
            k   = bitrev(m);
            sum = 0;
            for (int n = 0; n < N; n++)
                sum = (sum + longint'(x[n]) * (inv ? ipw[(n*k) % N] : pw[(n*k) % N])) % Q;
            if (inv) sum = (sum * N_INV) % Q;
            y[m] = DATA_W'(sum);
        end
        return y;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock of stimulus; outputs are sampled on the falling edge.
    task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit inv);
        in_valid = v;
        in_data  = d;
        inverse  = inv;
        @(negedge clk);
        if (v) begin
            if (out_valid) begin
                got_data.push_back(out_data);
                got_done.push_back(done_tick);
                if (first_acc < 0) first_acc = acc;
            end
            acc++;
        end else begin
            checkOutput("gap_out_valid", {31'd0, out_valid}, 32'd0);
            checkOutput("gap_done_tick", {31'd0, done_tick}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        got_data.delete();
        got_done.delete();
        acc       = 0;
        first_acc = -1;
    endtask

    task automatic resetDut(input bit check);
        in_valid = 1'b1;
        in_data  = 16'd1234;
        inverse  = 1'b1;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        if (check) begin
            checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
            checkOutput("rst_done_tick", {31'd0, done_tick}, 32'd0);
            checkOutput("rst_out_data", {16'd0, out_data}, 32'd0);
            checkOutput("rst_tw_addr", {16'd0, tw_addr}, 32'd0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        clearLog();
    endtask

    // Only sample 0 carries the frame's mode; the rest drive the opposite value.
    task automatic feedFrame(input int v, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps)
                for (int g = 0; g < 3 && $urandom_range(0, 99) < 30; g++)
                    applyStimulus(1'b0, 16'($urandom), 1'($urandom));
            applyStimulus(1'b1, vecs[v].x[i], (i == 0) ? vecs[v].inv : !vecs[v].inv);
        end
    endtask

    task automatic flush(input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 99) < 30) applyStimulus(1'b0, 16'($urandom), 1'($urandom));
            applyStimulus(1'b1, '0, 1'b0);
        end
    endtask

    task automatic compareFrames(input int first, input int count);
        int idx;
        checkOutput($sformatf("output_count_%s", vec_name[first]), got_data.size(), count * N);
        for (int f = 0; f < count; f++) begin
            for (int m = 0; m < N; m++) begin
                idx = f * N + m;
                if (idx < got_data.size()) begin
                    checkOutput($sformatf("%s[%0d]", vec_name[first+f], m),
                                {16'd0, got_data[idx]}, {16'd0, vecs[first+f].exp[m]});
                    checkOutput($sformatf("%s_done[%0d]", vec_name[first+f], m),
                                {31'd0, got_done[idx]}, {31'd0, (m == N - 1)});
                end
            end
        end
    endtask

    initial begin
        longint unsigned omega;
        longint unsigned w;

        n_checks = 0;
        n_fail   = 0;
        clearLog();

        omega = 0;
        for (int g = 2; g < 200 && omega == 0; g++) begin
            w = modpow(g, (Q - 1) / N);
            if (modpow(w, N / 2) == Q - 1) omega = w;
        end
        if (omega == 0) begin
            $display("[TB] FAIL omega_search: got 0, expected a primitive 16th root");
            $fatal(1, "[TB] no root of unity");
        end
        for (int e = 0; e < N; e++) pw[e] = 32'(modpow(omega, e));
        for (int e = 0; e < N; e++) ipw[e] = pw[(N - e) % N];

        vec_name = '{"impulse", "delta1", "dc5", "rand_fwd", "inv_of_rand",
                     "rand_fwd2", "rand_inv", "max_val"};
        for (int v = 0; v < NVEC; v++) begin
            vecs[v].inv = 1'b0;
            vecs[v].x   = '0;
            vecs[v].exp = '0;
        end
        for (int i = 0; i < N; i++) begin
            vecs[0].exp[i] = 16'd1;
            vecs[1].exp[i] = DATA_W'(pw[bitrev(i)]);
            vecs[2].x[i]   = 16'd5;
            vecs[3].x[i]   = DATA_W'($urandom_range(0, Q - 1));
            vecs[5].x[i]   = DATA_W'($urandom_range(0, Q - 1));
            vecs[6].x[i]   = DATA_W'($urandom_range(0, Q - 1));
            vecs[7].x[i]   = DATA_W'(Q - 1);
        end
        vecs[0].x[0]   = 16'd1;
        vecs[1].x[1]   = 16'd1;
        vecs[2].exp[0] = 16'd80;
        vecs[7].exp[0] = 16'd7665;
        vecs[3].exp    = golden(vecs[3].x, 1'b0);
        vecs[4].inv    = 1'b1;
        for (int k = 0; k < N; k++) begin
            vecs[4].x[k]   = vecs[3].exp[bitrev(k)];
            vecs[4].exp[k] = vecs[3].x[bitrev(k)];
        end
        vecs[5].exp = golden(vecs[5].x, 1'b0);
        vecs[6].inv = 1'b1;
        vecs[6].exp = golden(vecs[6].x, 1'b1);

        $display("[TB] back-to-back frames, mixed modes");
        resetDut(1'b1);
        for (int v = 0; v < NVEC; v++) feedFrame(v, 1'b0);
        flush(1'b0);
        checkOutput("latency_first_valid", first_acc, 32'd16);
        compareFrames(0, NVEC);

        $display("[TB] stalled stream");
        resetDut(1'b0);
        feedFrame(3, 1'b1);
        feedFrame(4, 1'b1);
        flush(1'b1);
        checkOutput("stall_latency_first_valid", first_acc, 32'd16);
        compareFrames(3, 2);

        $display("[TB] reset at sample 7");
        resetDut(1'b0);
        feedFrame(1, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, vecs[2].x[i], 1'b0);
        in_valid = 1'b1;
        in_data  = vecs[2].x[7];
        inverse  = 1'b0;
        #2;
        checkOutput("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_rst_done_tick", {31'd0, done_tick}, 32'd0);
        checkOutput("async_rst_out_data", {16'd0, out_data}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clearLog();
        feedFrame(5, 1'b0);
        flush(1'b0);
        checkOutput("post_rst_latency", first_acc, 32'd16);
        compareFrames(5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sdf_ntt_stream.md
Name: sdf_ntt_stream

Overview:
- Parametrised radix-2 DIF single-delay-feedback (SDF) NTT pipeline for N = 2^LOG_N points.
- Streams one coefficient per accepted cycle and supports forward and inverse transforms, with the mode latched per frame.
- Twiddles come from an external combinational ROM through per-stage address/data buses.
- Successor to the fixed 16-point SDF top: adds arbitrary depth, stall handshake, inverse mode with N^-1 scaling, and frame-done signalling.

Parameters:
- DATA_W, 16, coefficient width; must satisfy MODULO < 2^DATA_W.
- LOG_N, 4, log2 of transform size; legal range 2..10.
- MODULO, 7681, prime modulus q.
- N_INV, 7201, N^-1 mod q, used for inverse scaling (16^-1 mod 7681).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, in_data valid; the pipeline advances only when this is high.
- in_data, in, DATA_W, input coefficient in natural order, value < MODULO.
- inverse, in, 1, mode for the frame whose first sample is presented this cycle.
- tw_addr, out, LOG_N*LOG_N, per-stage {inv_bit, exponent[LOG_N-2:0]}; stage s occupies slice s.
- tw_data, in, LOG_N*DATA_W, per-stage twiddle, returned combinationally in the same cycle.
- out_valid, out, 1, out_data valid.
- out_data, out, DATA_W, transform output in bit-reversed order.
- done_tick, out, 1, one-cycle pulse coincident with the last output of each frame.

Behaviour:
- Reset (async, rst_n=0): clear all stage counters, delay lines, mode flags, fill counter, and output register. Outputs out_valid=0, done_tick=0, out_data=0, tw_addr=0.
- Advance: all state updates only on cycles with in_valid=1. in_valid=0 freezes every register, and out_valid=0 on those cycles. Host flushes the final frame by pushing zeros or the next frame.
- Stage s (0..LOG_N-1) has delay D_s = N>>(s+1), a counter c_s of width LOG_N-s, and a FIFO of depth D_s.
  - Phase A, c_s < D_s: fifo_in = x; stage_out = fifo_out (previous difference term).
  - Phase B, c_s >= D_s: a = fifo_out, b = x. stage_out = (a+b) mod q; fifo_in = ((a-b) mod q) * w mod q.
  - w = tw_data slice s; tw_addr slice s = {mode_s, (c_s - D_s) << s}, exponent truncated to LOG_N-1 bits.
  - c_s wraps at 2*D_s.
- Last stage (D=1) uses w=1 and needs no ROM lookup; its slice still drives {mode_s, 0}.
- Mode: stage 0 latches inverse when its counter is 0 and in_valid=1. Each stage s>0 latches mode_{s-1} delayed to its own frame boundary, so frames of different modes may coexist in the pipeline. Changing inverse mid-frame has no effect.
- Arithmetic:
  - Add/sub reduce with a single conditional correction (inputs < q).
  - Multiply yields a full 2*DATA_W product, reduced via the % operator / Barrett; result < q.
- Output stage: one register. Forward mode: out_data = last stage output. Inverse mode: out_data = last stage output * N_INV mod q. Both modes have identical latency.
- Latency: first output of a frame appears N accepted cycles after its first input (N-1 from delay lines plus 1 output register). Counted in accepted cycles, not clock cycles.
- out_valid goes high once the fill counter reaches N accepted samples and stays tied to in_valid thereafter.
- done_tick is asserted when out_valid=1 and the output index equals N-1. The output index counter wraps at N.
- Reset asserted mid-frame discards all partial data. The first in_valid after deassertion is treated as sample 0 of a new frame.

Test Plan:
- N=16, forward, input [1,0,...,0] -> 16 outputs all 1, out_valid first high on 16th accepted cycle after sample 0, done_tick on 16th output.
- N=16, forward, input [0,1,0,...,0] -> out[k] = omega^bitrev(k) mod 7681, compared to a golden model with the ROM table.
- Forward frame of random coeffs, then its bit-reverse-reordered output fed back with inverse=1 -> original coeffs exactly; back-to-back frames with no bubble.
- Random in_valid gaps (~30% low) on a two-frame stream -> output sequence identical to the no-stall run; out_valid=0 during gaps.
- Frame A forward immediately followed by frame B inverse -> each frame matches its own golden result, with no mode bleed between frames.
- rst_n pulsed low at sample 7 of a frame -> out_valid/done_tick drop asynchronously. A full new frame then gives a correct result with latency 16.
